sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 32 +++
 rtl/sram_arbiter_array.sv | 51 +++++
 rtl/sram_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared state encoding, RAM sizing constant and clog2 helper
//               for the SRAM arbiter and its RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Widest word address the device single-port RAM macro can decode;
    // wider addresses alias onto it.
    localparam int c_SPRAM_MAX_AW = 14;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_array
// Description : Single-port RAM wrapper, one-cycle registered read. Depth is
//               2^ADDRESS_BUS_WIDTH capped at the device macro size; upper
//               address bits beyond the cap alias.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array
    import sram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         write_enable,
    input  logic [ADDRESS_BUS_WIDTH-1:0] address,
    input  logic [DATA_BUS_WIDTH-1:0]    write_data,
    output logic [DATA_BUS_WIDTH-1:0]    read_data
);

    localparam int c_DEPTH_AW = (ADDRESS_BUS_WIDTH < c_SPRAM_MAX_AW) ?
                                ADDRESS_BUS_WIDTH : c_SPRAM_MAX_AW;
    localparam int c_DEPTH    = 1 << c_DEPTH_AW;

    logic [DATA_BUS_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_BUS_WIDTH-1:0] r_read_data;
    logic [c_DEPTH_AW-1:0]     w_index;

    assign w_index = address[c_DEPTH_AW-1:0];

    generate
        if (ADDRESS_BUS_WIDTH > c_DEPTH_AW) begin : g_addr_alias
            logic w_unused_high_bits;
            assign w_unused_high_bits = ^address[ADDRESS_BUS_WIDTH-1:c_DEPTH_AW];
        end
    endgenerate

    // Single port: a write cycle does not refresh the read register.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            r_mem[w_index] <= write_data;
        end else begin
            r_read_data <= r_mem[w_index];
        end
    end

    assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one single-port RAM between a buffered SPI write port
//               and OUTPUT_COUNT round-robin read channels. Writes outrank
//               reads; each read takes IDLE -> READ -> DONE with a one-cycle
//               completion strobe in DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int                           ADDRESS_BUS_WIDTH = 16,
    parameter int                           DATA_BUS_WIDTH    = 16,
    parameter int                           OUTPUT_COUNT      = 4,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] REG_SPACE_BASE    = 16'hFF00
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0]              write_address,
    input  logic [DATA_BUS_WIDTH-1:0]                 write_data,
    input  logic                                      write_strobe,
    input  logic [OUTPUT_COUNT-1:0]                   read_requests,
    input  logic [OUTPUT_COUNT*ADDRESS_BUS_WIDTH-1:0] read_addresses,
    output logic [DATA_BUS_WIDTH-1:0]                 read_data,
    output logic [OUTPUT_COUNT-1:0]                   read_finished_strobes,
    output logic                                      write_overflow,
    output logic [1:0]                                state
);

    localparam int c_GW = (OUTPUT_COUNT > 1) ? clog2(OUTPUT_COUNT) : 1;

    arb_state_t                   r_state;
    logic [ADDRESS_BUS_WIDTH-1:0] r_buf_addr;
    logic [DATA_BUS_WIDTH-1:0]    r_buf_data;
    logic                         r_buf_valid;
    logic                         r_overflow;
    logic [c_GW-1:0]              r_grant;
    logic [c_GW-1:0]              r_last_grant;
    logic [DATA_BUS_WIDTH-1:0]    r_read_data;
    logic [OUTPUT_COUNT-1:0]      r_strobes;

    logic                         w_accept;
    logic                         w_draining;
    logic                         w_any_req;
    logic [c_GW-1:0]              w_pick;
    logic [ADDRESS_BUS_WIDTH-1:0] w_pick_addr;
    int                           w_best_dist;
    logic [OUTPUT_COUNT-1:0]      w_grant_onehot;
    logic [ADDRESS_BUS_WIDTH-1:0] w_ram_addr;
    logic [DATA_BUS_WIDTH-1:0]    w_ram_rdata;

    // Register-space writes are decoded elsewhere and never touch the RAM.
    assign w_accept   = write_strobe && (write_address < REG_SPACE_BASE);
    // The buffered write owns the RAM in any IDLE cycle it is valid.
    assign w_draining = (r_state == ST_IDLE) && r_buf_valid;
    assign w_any_req  = |read_requests;

    // Round-robin pick: smallest distance after the last granted channel.
    always_comb begin
        w_pick      = r_last_grant;
        w_pick_addr = read_addresses[ADDRESS_BUS_WIDTH-1:0];
        w_best_dist = OUTPUT_COUNT;
        for (int c = 0; c < OUTPUT_COUNT; c++) begin
            if (read_requests[c] &&
                (((c + OUTPUT_COUNT - 1 - int'(r_last_grant)) % OUTPUT_COUNT) < w_best_dist)) begin
                w_best_dist = (c + OUTPUT_COUNT - 1 - int'(r_last_grant)) % OUTPUT_COUNT;
                w_pick      = c_GW'(c);
                w_pick_addr = read_addresses[c*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
            end
        end
    end

    // Decode the active grant into its strobe position.
    always_comb begin
        w_grant_onehot = '0;
        for (int c = 0; c < OUTPUT_COUNT; c++) begin
            w_grant_onehot[c] = (r_grant == c_GW'(c));
        end
    end

    assign w_ram_addr = w_draining ? r_buf_addr : w_pick_addr;

    sram_array #(
        .ADDRESS_BUS_WIDTH (ADDRESS_BUS_WIDTH),
        .DATA_BUS_WIDTH    (DATA_BUS_WIDTH)
    ) u_sram_array (
        .clk          (clk),
        .write_enable (w_draining),
        .address      (w_ram_addr),
        .write_data   (r_buf_data),
        .read_data    (w_ram_rdata)
    );

    // One-entry write buffer; a newer write replaces a stalled one and flags it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf_addr  <= write_address;
                r_buf_data  <= write_data;
                r_buf_valid <= 1'b1;
                if (r_buf_valid && !w_draining) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_draining) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    // Read arbitration FSM with registered data and completion strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_GW'(OUTPUT_COUNT - 1);
            r_read_data  <= '0;
            r_strobes    <= '0;
        end else begin
            r_strobes <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_buf_valid && w_any_req) begin
                        r_grant <= w_pick;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_read_data  <= w_ram_rdata;
                    r_strobes    <= w_grant_onehot;
                    r_last_grant <= r_grant;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_data             = r_read_data;
    assign read_finished_strobes = r_strobes;
    assign write_overflow        = r_overflow;
    assign state                 = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter: vector table, directed
//               multi-cycle sequences and randomized rounds against a
//               transaction-level memory / round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   write_address = '0;
    logic [DW-1:0]   write_data = '0;
    logic            write_strobe = 1'b0;
    logic [N-1:0]    read_requests = '0;
    logic [N*AW-1:0] read_addresses = '0;
    logic [DW-1:0]   read_data;
    logic [N-1:0]    read_finished_strobes;
    logic            write_overflow;
    logic [1:0]      state;

    int tests = 0;
    int fails = 0;
    int ref_last;
    logic [DW-1:0] ref_mem [0:16383];

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] base;
        int          exp_ch;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [9];

    sram_arbiter #(
        .ADDRESS_BUS_WIDTH (AW),
        .DATA_BUS_WIDTH    (DW),
        .OUTPUT_COUNT      (N),
        .REG_SPACE_BASE    (16'hFF00)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .write_address         (write_address),
        .write_data            (write_data),
        .write_strobe          (write_strobe),
        .read_requests         (read_requests),
        .read_addresses        (read_addresses),
        .read_data             (read_data),
        .read_finished_strobes (read_finished_strobes),
        .write_overflow        (write_overflow),
        .state                 (state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference round-robin: first requester after the last grant.
    function automatic int rr_pick(input int last, input logic [3:0] mask);
        logic [3:0] m;
        m = mask;
        for (int s = 1; s <= N; s++) begin
            if (m[2'((last + s) % N)]) return (last + s) % N;
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_strobes", 32'(read_finished_strobes), 32'd0);
        check("rst_overflow", 32'(write_overflow), 32'd0);
        tick;
        rst = 1'b1;
        ref_last = N - 1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        write_address = addr;
        write_data    = data;
        write_strobe  = 1'b1;
        tick;
        write_strobe  = 1'b0;
        if (addr < 16'hFF00) ref_mem[addr & 16'h3FFF] = data;
    endtask

    task automatic set_reqs(input logic [3:0] mask, input logic [15:0] base);
        read_requests = mask;
        for (int i = 0; i < N; i++) read_addresses[i*AW +: AW] = base + 16'(i);
    endtask

    task automatic wait_strobe(output int ch, output int n);
        n  = 0;
        ch = -1;
        while (read_finished_strobes == '0 && n < 12) begin
            tick;
            n++;
        end
        if (read_finished_strobes == '0) begin
            tests++;
            fails++;
            $display("FAIL strobe_timeout: got no strobe in %0d cycles, required one", n);
        end
        for (int i = 0; i < N; i++) begin
            if (read_finished_strobes == (4'b1 << i)) ch = i;
        end
    endtask

    task automatic do_round(input string name, input logic [3:0] mask, input logic [15:0] base,
                            input int exp_ch, input logic [15:0] exp_data);
        int ch;
        int n;
        set_reqs(mask, base);
        wait_strobe(ch, n);
        read_requests = '0;
        check({name, "_channel"}, 32'(ch), 32'(exp_ch));
        check({name, "_data"}, 32'(read_data), 32'(exp_data));
        check({name, "_latency"}, 32'(n), 32'd2);
        tick;
        check({name, "_pulse_width"}, 32'(read_finished_strobes), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

    initial begin
        int ch;
        int n;
        int exp;
        logic [15:0] a;
        logic [15:0] base;
        logic [3:0]  mask;

        vecs[0] = '{4'hF, 16'd0,  0, 16'hA500};
        vecs[1] = '{4'hF, 16'd4,  1, 16'hA505};
        vecs[2] = '{4'h1, 16'd8,  0, 16'hA508};
        vecs[3] = '{4'h8, 16'd12, 3, 16'hA50F};
        vecs[4] = '{4'h6, 16'd16, 1, 16'hA511};
        vecs[5] = '{4'h6, 16'd20, 2, 16'hA516};
        vecs[6] = '{4'h6, 16'd24, 1, 16'hA519};
        vecs[7] = '{4'h9, 16'd2,  3, 16'hA505};
        vecs[8] = '{4'h9, 16'd1,  0, 16'hA501};

        #1;
        do_reset;

        // Known contents for addresses 0..31.
        for (int i = 0; i < 32; i++) do_write(16'(i), 16'hA500 | 16'(i));
        tick;
        check("prefill_no_overflow", 32'(write_overflow), 32'd0);

        for (int v = 0; v < 9; v++) begin
            do_round($sformatf("vec%0d", v), vecs[v].mask, vecs[v].base, vecs[v].exp_ch, vecs[v].exp_data);
        end

        // Write then read on channel 0, stage by stage.
        do_write(16'h0010, 16'h1234);
        tick;
        set_reqs(4'b0001, 16'h0010);
        tick;
        check("raw_read_state", 32'(state), 32'd1);
        check("raw_no_early_strobe", 32'(read_finished_strobes), 32'd0);
        tick;
        check("raw_done_state", 32'(state), 32'd2);
        check("raw_strobe", 32'(read_finished_strobes), 32'd1);
        check("raw_data", 32'(read_data), 32'h1234);
        read_requests = '0;
        tick;
        check("raw_back_idle", 32'(state), 32'd0);
        check("raw_strobe_cleared", 32'(read_finished_strobes), 32'd0);

        // All four channels request continuously.
        do_reset;
        set_reqs(4'hF, 16'd0);
        for (int k = 0; k < 5; k++) begin
            wait_strobe(ch, n);
            check($sformatf("rr%0d_channel", k), 32'(ch), 32'(k % N));
            check($sformatf("rr%0d_data", k), 32'(read_data), 32'(ref_mem[k % N]));
            check($sformatf("rr%0d_latency", k), 32'(n), 32'd2);
            if (k == 4) read_requests = '0;
            tick;
            check($sformatf("rr%0d_pulse_width", k), 32'(read_finished_strobes), 32'd0);
        end

        // Write arriving while channel 2 is in READ.
        set_reqs(4'b0100, 16'd3);
        tick;
        check("wr_in_read_state", 32'(state), 32'd1);
        write_address = 16'd6;
        write_data    = 16'hBEEF;
        write_strobe  = 1'b1;
        tick;
        write_strobe  = 1'b0;
        read_requests = '0;
        ref_mem[6]    = 16'hBEEF;
        check("wr_in_read_strobe", 32'(read_finished_strobes), 32'h4);
        check("wr_in_read_data", 32'(read_data), 32'hA505);
        tick;
        tick;
        check("wr_in_read_overflow", 32'(write_overflow), 32'd0);
        do_round("wr_in_read_readback", 4'b0100, 16'd4, 2, 16'hBEEF);

        // Back-to-back writes while the FSM is busy: second one wins, flag sticks.
        set_reqs(4'b0001, 16'd0);
        tick;
        write_address = 16'd7;
        write_data    = 16'h1111;
        write_strobe  = 1'b1;
        tick;
        write_data    = 16'h2222;
        read_requests = '0;
        check("ovf_read_strobe", 32'(read_finished_strobes), 32'h1);
        tick;
        write_strobe  = 1'b0;
        ref_mem[7]    = 16'h2222;
        check("ovf_flag_set", 32'(write_overflow), 32'd1);
        tick;
        do_round("ovf_readback", 4'b1000, 16'd4, 3, 16'h2222);
        check("ovf_flag_sticky", 32'(write_overflow), 32'd1);
        do_reset;

        // Register-space write is ignored and leaves the buffer empty.
        do_write(16'h3F01, 16'h5A5A);
        do_write(16'hFF01, 16'hDEAD);
        set_reqs(4'b0001, 16'hFF01);
        tick;
        check("regspace_grant_immediate", 32'(state), 32'd1);
        tick;
        check("regspace_strobe", 32'(read_finished_strobes), 32'h1);
        check("regspace_ram_unchanged", 32'(read_data), 32'h5A5A);
        read_requests = '0;
        tick;

        // Reset in the middle of a read.
        set_reqs(4'b0010, 16'd0);
        tick;
        check("rst_mid_read_state", 32'(state), 32'd1);
        do_reset;
        do_round("rst_then_ch0", 4'b0011, 16'd0, 0, ref_mem[0]);
        ref_last = 0;

        // Randomized rounds against the reference model.
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 9) == 0) a = 16'hFF00 | 16'($urandom_range(0, 255));
                else a = 16'($urandom_range(0, 31));
                do_write(a, 16'($urandom));
                tick;
            end
            mask = 4'($urandom_range(1, 15));
            base = 16'($urandom_range(0, 28));
            exp  = rr_pick(ref_last, mask);
            do_round($sformatf("rand%0d", r), mask, base, exp, ref_mem[base + 16'(exp)]);
            ref_last = exp;
        end
        check("rand_no_overflow", 32'(write_overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
